// File: rtl/rom_req_arbiter.sv
// -----------------------------------------------------------------------------
// rom_req_arbiter
//
// Shares one single-port synchronous boot ROM (fixed 1-cycle read latency)
// between NumReq requesters. Each cycle at most one requester is granted. The
// grant drives the ROM chip-select and address, and the granted index is
// recorded as a tag. When the ROM read-valid returns one cycle later, the read
// data is registered and routed back to the tagged requester as a one-hot
// rvalid_o. The total latency from grant to rvalid_o is two cycles.
//
// Any break of the 1-cycle latency contract sets the sticky err_o flag:
//   - a ROM valid with nothing outstanding (spurious valid), or
//   - an outstanding read with no ROM valid (lost response).
//
// Configuration macro:
//   ROM_ARB_RR_EN  defined   : round-robin arbitration. The search starts one
//                              above the last granted index and wraps.
//                  undefined : fixed priority, where the lowest index wins.
//                              No pointer register is built.
//
// Ports:
//   clk_i         in   1            clock
//   rst_ni        in   1            asynchronous active-low reset
//   req_i         in   NumReq       per-requester read request (held until granted)
//   addr_i        in   NumReq*Aw    per-requester word address, slice [k*Aw +: Aw]
//   gnt_o         out  NumReq       one-hot grant, combinational from req_i
//   rvalid_o      out  NumReq       one-hot read-data valid (registered)
//   rdata_o       out  Width        read data, broadcast (registered)
//   rom_cs_o      out  1            ROM chip select (= |gnt_o)
//   rom_addr_o    out  Aw           granted address, zero when idle
//   rom_rdata_i   in   Width        ROM read data
//   rom_dvalid_i  in   1            ROM read valid, one cycle after rom_cs_o
//   err_o         out  1            sticky protocol-error flag
// -----------------------------------------------------------------------------
module rom_req_arbiter #(
    parameter int NumReq = 2,
    parameter int Width  = 32,
    parameter int Depth  = 2048,
    parameter int Aw     = $clog2(Depth),
    parameter int IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NumReq-1:0]    req_i,
    input  logic [NumReq*Aw-1:0] addr_i,
    output logic [NumReq-1:0]    gnt_o,
    output logic [NumReq-1:0]    rvalid_o,
    output logic [Width-1:0]     rdata_o,
    output logic                 rom_cs_o,
    output logic [Aw-1:0]        rom_addr_o,
    input  logic [Width-1:0]     rom_rdata_i,
    input  logic                 rom_dvalid_i,
    output logic                 err_o
);

    // Expands a requester index into a one-hot vector.
    function automatic logic [NumReq-1:0] onehot(input logic [IdxW-1:0] idx);
        logic [NumReq-1:0] v;
        v      = {NumReq{1'b0}};
        v[idx] = 1'b1;
        return v;
    endfunction

    logic              found_s;
    logic [IdxW-1:0]   gnt_idx_s;
    logic [NumReq-1:0] gnt_s;
    logic              rom_cs_s;
    logic [Aw-1:0]     rom_addr_s;

    logic              outstanding_r;
    logic [IdxW-1:0]   tag_r;
    logic [NumReq-1:0] rvalid_r;
    logic [Width-1:0]  rdata_r;
    logic              err_r;

`ifdef ROM_ARB_RR_EN
    logic [IdxW-1:0]   ptr_r;

    // Round-robin search: begin one above the last winner and wrap upward.
    always_comb begin
        found_s   = 1'b0;
        gnt_idx_s = {IdxW{1'b0}};
        for (int i = 0; i < NumReq; i++) begin
            int cand_v;
            cand_v = (int'(ptr_r) + 1 + i) % NumReq;
            if (!found_s && req_i[cand_v]) begin
                found_s   = 1'b1;
                gnt_idx_s = IdxW'(cand_v);
            end else begin
                found_s   = found_s;
            end
        end
    end

    // Pointer remembers the last granted index and holds on idle cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_r <= IdxW'(NumReq - 1);
        end else if (rom_cs_s) begin
            ptr_r <= gnt_idx_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end
`else
    // Fixed priority: scan downward so the lowest active index is assigned last and wins.
    always_comb begin
        found_s   = 1'b0;
        gnt_idx_s = {IdxW{1'b0}};
        for (int i = NumReq - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                found_s   = 1'b1;
                gnt_idx_s = IdxW'(i);
            end else begin
                found_s   = found_s;
            end
        end
    end
`endif

    // Grant decode and ROM drive. Grants are suppressed while reset is
    // asserted, so nothing reaches the ROM during reset.
    always_comb begin
        gnt_s      = {NumReq{1'b0}};
        rom_cs_s   = 1'b0;
        rom_addr_s = {Aw{1'b0}};
        if (rst_ni && found_s) begin
            gnt_s      = onehot(gnt_idx_s);
            rom_cs_s   = 1'b1;
            rom_addr_s = addr_i[int'(gnt_idx_s)*Aw +: Aw];
        end else begin
            gnt_s      = {NumReq{1'b0}};
        end
    end

    // Tag pipeline, response register and sticky latency-violation detector.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            outstanding_r <= 1'b0;
            tag_r         <= {IdxW{1'b0}};
            rvalid_r      <= {NumReq{1'b0}};
            rdata_r       <= {Width{1'b0}};
            err_r         <= 1'b0;
        end else begin
            outstanding_r <= rom_cs_s;
            tag_r         <= gnt_idx_s;
            if (rom_dvalid_i && outstanding_r) begin
                rvalid_r <= onehot(tag_r);
                rdata_r  <= rom_rdata_i;
            end else begin
                rvalid_r <= {NumReq{1'b0}};
                rdata_r  <= rdata_r;
            end
            // A valid without a read in flight, or a read in flight without a valid.
            if (rom_dvalid_i != outstanding_r) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    assign gnt_o      = gnt_s;
    assign rom_cs_o   = rom_cs_s;
    assign rom_addr_o = rom_addr_s;
    assign rvalid_o   = rvalid_r;
    assign rdata_o    = rdata_r;
    assign err_o      = err_r;

endmodule
